// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned addrWidth = 32;
  localparam int unsigned instWidth = 32;

  // rw_flag encodings shared with the cache-to-mem_ctrl link
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester ports I and D plus the mem_ctrl side.
// master: requesters and mem_ctrl; slave: the arbiter itself.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [1:0]        i_rw_flag;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_len;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_busy;
  logic              i_done;

  logic [1:0]        d_rw_flag;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_len;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_busy;
  logic              d_done;

  logic [1:0]        rw_flag_out;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        len_out;
  logic [DATA_W-1:0] wdata_out;
  logic [DATA_W-1:0] read_data;
  logic              mem_busy;
  logic              mem_done;

  modport master (
    output i_rw_flag, i_addr, i_len, i_wdata,
    input  i_rdata, i_busy, i_done,
    output d_rw_flag, d_addr, d_len, d_wdata,
    input  d_rdata, d_busy, d_done,
    input  rw_flag_out, addr_out, len_out, wdata_out,
    output read_data, mem_busy, mem_done
  );

  modport slave (
    input  i_rw_flag, i_addr, i_len, i_wdata,
    output i_rdata, i_busy, i_done,
    input  d_rw_flag, d_addr, d_len, d_wdata,
    output d_rdata, d_busy, d_done,
    output rw_flag_out, addr_out, len_out, wdata_out,
    input  read_data, mem_busy, mem_done
  );

endinterface

// File: rtl/mem_arbiter_arb_req_slot.sv
// arb_req_slot: single-entry latch for one requester's pending access.
// A capture into an empty slot latches the request; clear empties it.
module arb_req_slot #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              capture,
  input  logic              clear,
  input  logic [1:0]        flag_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        len_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              valid,
  output logic [1:0]        flag,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        len,
  output logic [DATA_W-1:0] wdata
);

  // Hold one request; a pulse while full is dropped.
  always_ff @(negedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      flag  <= '0;
      addr  <= '0;
      len   <= '0;
      wdata <= '0;
    end else if (rdy) begin
      if (clear) begin
        valid <= 1'b0;
      end else if (capture && !valid) begin
        valid <= 1'b1;
        flag  <= flag_in;
        addr  <= addr_in;
        len   <= len_in;
        wdata <= wdata_in;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_ctrl port between the I-cache (I) and LSU (D).
// Registers update on negedge clk. Optional macro MEM_ARB_RR_EN selects
// round-robin priority; otherwise D always beats I.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = addrWidth,
  parameter int unsigned DATA_W = instWidth
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  mem_arbiter_if.slave bus
);

  arb_state_e state, nxt_state;

  logic              i_cap, d_cap, i_clr, d_clr;
  logic              i_valid, d_valid;
  logic [1:0]        i_flag, d_flag;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [1:0]        i_len, d_len;
  logic [DATA_W-1:0] i_wdata, d_wdata;

  logic              i_req, d_req;
  logic [1:0]        i_eflag, d_eflag;
  logic [ADDR_W-1:0] i_eaddr, d_eaddr;
  logic [1:0]        i_elen, d_elen;
  logic [DATA_W-1:0] i_ewdata, d_ewdata;

  logic [1:0]        rw_q, nxt_rw;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic [1:0]        len_q, nxt_len;
  logic [DATA_W-1:0] wdata_q, nxt_wdata;
  logic [DATA_W-1:0] i_rdata_q, nxt_i_rdata, d_rdata_q, nxt_d_rdata;
  logic              i_done_q, nxt_i_done, d_done_q, nxt_d_done;

  logic              prefer_d;
  logic              mem_busy_unused;

  assign mem_busy_unused = bus.mem_busy;

  assign i_cap = (bus.i_rw_flag != RW_IDLE) && !i_valid;
  assign d_cap = (bus.d_rw_flag != RW_IDLE) && !d_valid;

  arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_i (
    .clk(clk), .rst(rst), .rdy(rdy), .capture(i_cap), .clear(i_clr),
    .flag_in(bus.i_rw_flag), .addr_in(bus.i_addr), .len_in(bus.i_len),
    .wdata_in(bus.i_wdata), .valid(i_valid), .flag(i_flag), .addr(i_addr),
    .len(i_len), .wdata(i_wdata)
  );

  arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_d (
    .clk(clk), .rst(rst), .rdy(rdy), .capture(d_cap), .clear(d_clr),
    .flag_in(bus.d_rw_flag), .addr_in(bus.d_addr), .len_in(bus.d_len),
    .wdata_in(bus.d_wdata), .valid(d_valid), .flag(d_flag), .addr(d_addr),
    .len(d_len), .wdata(d_wdata)
  );

  // A request captured this edge is bypassed straight to the issue mux so an
  // idle arbiter issues at the capture edge rather than one edge later.
  assign i_req    = i_valid | i_cap;
  assign d_req    = d_valid | d_cap;
  assign i_eflag  = i_cap ? bus.i_rw_flag : i_flag;
  assign d_eflag  = d_cap ? bus.d_rw_flag : d_flag;
  assign i_eaddr  = i_cap ? bus.i_addr    : i_addr;
  assign d_eaddr  = d_cap ? bus.d_addr    : d_addr;
  assign i_elen   = i_cap ? bus.i_len     : i_len;
  assign d_elen   = d_cap ? bus.d_len     : d_len;
  assign i_ewdata = i_cap ? bus.i_wdata   : i_wdata;
  assign d_ewdata = d_cap ? bus.d_wdata   : d_wdata;

`ifdef MEM_ARB_RR_EN
  port_e last_grant, nxt_last_grant;
  assign prefer_d = (last_grant == PORT_I);
`else
  assign prefer_d = 1'b1;
`endif

  // Next-state, issue and completion decode.
  always_comb begin
    nxt_state   = state;
    nxt_rw      = RW_IDLE;
    nxt_addr    = addr_q;
    nxt_len     = len_q;
    nxt_wdata   = wdata_q;
    nxt_i_rdata = i_rdata_q;
    nxt_d_rdata = d_rdata_q;
    nxt_i_done  = 1'b0;
    nxt_d_done  = 1'b0;
    i_clr       = 1'b0;
    d_clr       = 1'b0;
`ifdef MEM_ARB_RR_EN
    nxt_last_grant = last_grant;
`endif
    case (state)
      IDLE: begin
        if (d_req && (prefer_d || !i_req)) begin
          nxt_rw    = d_eflag;
          nxt_addr  = d_eaddr;
          nxt_len   = d_elen;
          nxt_wdata = d_ewdata;
          nxt_state = SERVE_D;
`ifdef MEM_ARB_RR_EN
          nxt_last_grant = PORT_D;
`endif
        end else if (i_req) begin
          nxt_rw    = i_eflag;
          nxt_addr  = i_eaddr;
          nxt_len   = i_elen;
          nxt_wdata = i_ewdata;
          nxt_state = SERVE_I;
`ifdef MEM_ARB_RR_EN
          nxt_last_grant = PORT_I;
`endif
        end
      end
      SERVE_I: begin
        if (bus.mem_done) begin
          nxt_i_rdata = bus.read_data;
          nxt_i_done  = 1'b1;
          i_clr       = 1'b1;
          nxt_state   = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.mem_done) begin
          nxt_d_rdata = bus.read_data;
          nxt_d_done  = 1'b1;
          d_clr       = 1'b1;
          nxt_state   = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State register (and grant history when round-robin is built in).
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef MEM_ARB_RR_EN
      last_grant <= PORT_I;
`endif
    end else if (rdy) begin
      state <= nxt_state;
`ifdef MEM_ARB_RR_EN
      last_grant <= nxt_last_grant;
`endif
    end
  end

  // Registered outputs toward mem_ctrl and back to the requesters.
  always_ff @(negedge clk) begin
    if (rst) begin
      rw_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else if (rdy) begin
      rw_q      <= nxt_rw;
      addr_q    <= nxt_addr;
      len_q     <= nxt_len;
      wdata_q   <= nxt_wdata;
      i_rdata_q <= nxt_i_rdata;
      d_rdata_q <= nxt_d_rdata;
      i_done_q  <= nxt_i_done;
      d_done_q  <= nxt_d_done;
    end
  end

  assign bus.rw_flag_out = rw_q;
  assign bus.addr_out    = addr_q;
  assign bus.len_out     = len_q;
  assign bus.wdata_out   = wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_done      = i_done_q;
  assign bus.d_done      = d_done_q;
  assign bus.i_busy      = i_valid;
  assign bus.d_busy      = d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected issues
// and completions (with the negedge count at which they must appear); a
// monitor sampling on posedge pops and compares.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   ne = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [1:0]  flag;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    int          at;
  } iss_t;

  typedef struct {
    logic [31:0] data;
    int          at;
  } dn_t;

  iss_t iss_q[$];
  dn_t  i_q[$];
  dn_t  d_q[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // DUT registers on negedge; count those edges for latency expectations.
  always @(negedge clk) ne <= ne + 1;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an issue or done.
  always @(posedge clk) begin
    iss_t e;
    dn_t  c;
    if (mon_en) begin
      if (bus.rw_flag_out !== 2'b00) begin
        if (iss_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got flag=%b addr=%h at edge %0d, required none",
                   bus.rw_flag_out, bus.addr_out, ne);
        end else begin
          e = iss_q.pop_front();
          check("issue", 128'({bus.rw_flag_out, bus.addr_out, bus.len_out, bus.wdata_out, ne}),
                128'({e.flag, e.addr, e.len, e.wdata, e.at}));
        end
      end
      if (bus.i_done !== 1'b0) begin
        check("done_exclusive", 128'(bus.d_done), 128'(0));
        if (i_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL i_done_unexpected: got i_done with i_rdata=%h at edge %0d, required none",
                   bus.i_rdata, ne);
        end else begin
          c = i_q.pop_front();
          check("i_done", 128'({bus.i_rdata, ne}), 128'({c.data, c.at}));
        end
      end
      if (bus.d_done !== 1'b0) begin
        if (d_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_done_unexpected: got d_done with d_rdata=%h at edge %0d, required none",
                   bus.d_rdata, ne);
        end else begin
          c = d_q.pop_front();
          check("d_done", 128'({bus.d_rdata, ne}), 128'({c.data, c.at}));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic mem_done_pulse(input logic [31:0] data);
    bus.mem_done  = 1'b1;
    bus.read_data = data;
    tick();
    bus.mem_done  = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_mem"}, 128'({bus.rw_flag_out, bus.addr_out, bus.len_out, bus.wdata_out}), 128'(0));
    check({name, "_req"}, 128'({bus.i_rdata, bus.d_rdata, bus.i_busy, bus.d_busy,
                                bus.i_done, bus.d_done}), 128'(0));
  endtask

  // I read and D write pulsed together: D issues first, one idle cycle, then I.
  task automatic run_pair(input logic [31:0] ai, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [31:0] ri,
                          input logic [31:0] rd);
    int k;
    k = ne;
    bus.i_rw_flag = RW_READ;  bus.i_addr = ai; bus.i_len = 2'd0; bus.i_wdata = '0;
    bus.d_rw_flag = RW_WRITE; bus.d_addr = ad; bus.d_len = 2'd2; bus.d_wdata = wd;
    iss_q.push_back('{RW_WRITE, ad, 2'd2, wd, k + 1});
    iss_q.push_back('{RW_READ, ai, 2'd0, 32'h0, k + 4});
    tick();
    bus.i_rw_flag = RW_IDLE;
    bus.d_rw_flag = RW_IDLE;
    check("pair_busy", 128'({bus.i_busy, bus.d_busy}), 128'(2'b11));
    tick();
    d_q.push_back('{rd, ne + 1});
    mem_done_pulse(rd);
    tick();
    i_q.push_back('{ri, ne + 1});
    mem_done_pulse(ri);
    tick();
  endtask

  initial begin
    int k;
    bus.i_rw_flag = '0; bus.i_addr = '0; bus.i_len = '0; bus.i_wdata = '0;
    bus.d_rw_flag = '0; bus.d_addr = '0; bus.d_len = '0; bus.d_wdata = '0;
    bus.read_data = '0; bus.mem_busy = 1'b0; bus.mem_done = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // single I read, done three edges after issue
    k = ne;
    bus.i_rw_flag = RW_READ; bus.i_addr = 32'h0000_1000; bus.i_len = 2'd2; bus.i_wdata = '0;
    iss_q.push_back('{RW_READ, 32'h0000_1000, 2'd2, 32'h0, k + 1});
    tick();
    bus.i_rw_flag = RW_IDLE;
    check("t1_i_busy_set", 128'(bus.i_busy), 128'(1));
    repeat (2) tick();
    i_q.push_back('{32'hDEAD_BEEF, ne + 1});
    mem_done_pulse(32'hDEAD_BEEF);
    check("t1_i_busy_clear", 128'(bus.i_busy), 128'(0));
    tick();

    // simultaneous pulses
    run_pair(32'h0000_0100, 32'h0000_0200, 32'h1234_5678, 32'h5555_AAAA, 32'hAAAA_0000);

    // D pulse during SERVE_I
    k = ne;
    bus.i_rw_flag = RW_READ; bus.i_addr = 32'h0000_0300; bus.i_len = 2'd1; bus.i_wdata = '0;
    iss_q.push_back('{RW_READ, 32'h0000_0300, 2'd1, 32'h0, k + 1});
    tick();
    bus.i_rw_flag = RW_IDLE;
    tick();
    bus.d_rw_flag = RW_READ; bus.d_addr = 32'h0000_0400; bus.d_len = 2'd3; bus.d_wdata = 32'h0000_CAFE;
    iss_q.push_back('{RW_READ, 32'h0000_0400, 2'd3, 32'h0000_CAFE, k + 5});
    tick();
    bus.d_rw_flag = RW_IDLE;
    check("t3_busy_both", 128'({bus.i_busy, bus.d_busy}), 128'(2'b11));
    i_q.push_back('{32'h1111_1111, ne + 1});
    mem_done_pulse(32'h1111_1111);
    repeat (2) tick();
    d_q.push_back('{32'h2222_2222, ne + 1});
    mem_done_pulse(32'h2222_2222);
    tick();

    // three contention rounds: order D, I each round
    for (int r = 0; r < 3; r++) begin
      run_pair(32'h0000_1100 + 32'(r), 32'h0000_2200 + 32'(r), 32'h0BAD_0000 + 32'(r),
               32'h0000_00A0 + 32'(r), 32'h0000_00D0 + 32'(r));
    end

    // reset during SERVE_D abandons the transaction
    k = ne;
    bus.d_rw_flag = RW_READ; bus.d_addr = 32'h0000_0500; bus.d_len = 2'd0; bus.d_wdata = '0;
    iss_q.push_back('{RW_READ, 32'h0000_0500, 2'd0, 32'h0, k + 1});
    tick();
    bus.d_rw_flag = RW_IDLE;
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    mem_done_pulse(32'h0000_0BAD);
    tick();
    k = ne;
    bus.i_rw_flag = RW_READ; bus.i_addr = 32'h0000_0700; bus.i_len = 2'd2; bus.i_wdata = '0;
    iss_q.push_back('{RW_READ, 32'h0000_0700, 2'd2, 32'h0, k + 1});
    tick();
    bus.i_rw_flag = RW_IDLE;
    tick();
    i_q.push_back('{32'h7777_7777, ne + 1});
    mem_done_pulse(32'h7777_7777);
    tick();

    // rdy low with mem_done held: frozen, then completes when rdy returns
    k = ne;
    bus.i_rw_flag = RW_READ; bus.i_addr = 32'h0000_0600; bus.i_len = 2'd2; bus.i_wdata = '0;
    iss_q.push_back('{RW_READ, 32'h0000_0600, 2'd2, 32'h0, k + 1});
    tick();
    bus.i_rw_flag = RW_IDLE;
    tick();
    rdy = 1'b0;
    bus.mem_done = 1'b1;
    bus.read_data = 32'h6666_6666;
    repeat (4) begin
      tick();
      check("rdy_hold", 128'({bus.i_busy, bus.i_done}), 128'(2'b10));
    end
    rdy = 1'b1;
    i_q.push_back('{32'h6666_6666, ne + 1});
    tick();
    bus.mem_done = 1'b0;
    repeat (3) tick();

    check("iss_q_drained", 128'(iss_q.size()), 128'(0));
    check("i_q_drained", 128'(i_q.size()), 128'(0));
    check("d_q_drained", 128'(d_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory controller port between two requesters: the instruction cache (port I) and the load/store unit (port D).
- Latches one-cycle request pulses, issues them to mem_ctrl one at a time, and routes `read_data` and `done` back to the owning requester.
- Sits between the caches/LSU and mem_ctrl.
- Uses the same `rw_flag`/`len`/`busy`/`done` protocol as the cache-to-mem_ctrl link.

Parameters:
- ADDR_W, 32, address width (equals `addrWidth` in defines.vh).
- DATA_W, 32, data width (equals `instWidth` in defines.vh).

Ports:
- clk  in  1  clock; all registers update on negedge clk.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low all state holds.
- i_rw_flag  in  2  port I request pulse: [0] read, [1] write, 00 idle.
- i_addr  in  ADDR_W  port I address.
- i_len  in  2  port I access length code (passed through).
- i_wdata  in  DATA_W  port I write data.
- i_rdata  out  DATA_W  port I returned data.
- i_busy  out  1  port I request pending or in service.
- i_done  out  1  port I one-cycle completion pulse.
- d_rw_flag, d_addr, d_len, d_wdata, d_rdata, d_busy, d_done: same as the port I signals, for port D.
- rw_flag_out  out  2  request pulse to mem_ctrl.
- addr_out  out  ADDR_W  address to mem_ctrl.
- len_out  out  2  length to mem_ctrl.
- wdata_out  out  DATA_W  write data to mem_ctrl.
- read_data  in  DATA_W  data from mem_ctrl.
- mem_busy  in  1  mem_ctrl busy.
- mem_done  in  1  mem_ctrl completion pulse.

Behaviour:
- Reset:
  - All outputs are 0.
  - Both pending slots are cleared.
  - State is IDLE.
  - rst has priority over rdy.
  - Reset mid-transaction abandons it silently; no done pulse is produced.
- rdy low: no register changes. Incoming pulses in that cycle are lost; requesters do not pulse while rdy is low.
- Request capture: on an edge with `x_rw_flag != 0` and slot x empty:
  - latch flag, addr, len and wdata into slot x;
  - set x_busy = 1 at that same edge.
- A pulse while slot x is full is ignored. This is a protocol violation; the requester waits for x_done.
- States:
  - IDLE: if any slot is full (including one captured this edge), select a winner by priority. Drive rw_flag_out/addr_out/len_out/wdata_out from the winner's slot for exactly one cycle, then go to SERVE_I or SERVE_D.
  - SERVE_x: rw_flag_out = 0 and the address/len/wdata outputs hold.
    - On mem_done: x_rdata <= read_data; x_done <= 1 for one cycle; x_busy <= 0; clear slot x; go to IDLE.
  - IDLE can issue the next pending slot at the edge after a done, giving one idle cycle between back-to-back transactions.
- Latency: request pulse sampled at edge N with an idle arbiter gives rw_flag_out high for edge N+1 only. x_done is asserted at the edge where mem_done is sampled.
- Priority (default): fixed, D over I.
- Simultaneous events:
  - Both pulses at the same edge: both are captured; D is issued first.
  - A new pulse on the idle port during the other port's service is captured and issued after.
  - A pulse arriving at the same edge as mem_done is captured.
- x_rdata holds its last value until the next completion for x. Writes also return read_data, which is don't-care.
- i_done and d_done are never high in the same cycle.
- mem_busy is informational only: the arbiter never issues outside IDLE.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin priority; a `last_grant` bit tracks the most recently served port.
  - On contention in IDLE, the port not equal to `last_grant` wins.
  - `last_grant` resets to I, so D wins the first contention.
- Undefined: fixed D-over-I priority and no `last_grant` register.

Decomposition:
- Shared package / defines.vh:
  - rw_flag encodings (RW_IDLE=2'b00, RW_READ=2'b01, RW_WRITE=2'b10);
  - arbiter state encodings (IDLE, SERVE_I, SERVE_D);
  - addrWidth and instWidth.
- One sub-module, `arb_req_slot`: a single-entry request latch holding valid, flag, addr, len and wdata, with capture and clear inputs. It is instantiated twice.

Test Plan:
1. I read pulse, addr 0x0000_1000, arbiter idle:
   - rw_flag_out = 01 and addr_out = 0x1000 for exactly one cycle.
   - mem_done 3 cycles later with read_data 0xDEADBEEF gives i_done pulse and i_rdata = 0xDEADBEEF.
2. I read (0x100) and D write (0x200, wdata 0x12345678) pulsed at the same edge:
   - D is issued first with wdata_out = 0x12345678; d_done is returned.
   - One idle cycle follows, then I is issued at 0x100.
3. D request pulsed while I is in SERVE_I: d_busy rises immediately; D is issued one cycle after i_done.
4. With MEM_ARB_RR_EN: three rounds of both ports pulsing together give the grant order D, I, D, I, D, I. Without the macro the order is D, I on each round.
5. rst asserted during SERVE_D:
   - All outputs are 0 next edge and no d_done is produced.
   - A later mem_done is ignored.
   - A subsequent I read completes normally.
6. rdy low for 4 cycles while mem_done is high:
   - No state change and no done pulse.
   - When rdy returns with mem_done still high, completion occurs.
